// File: rtl/reservation_station_pkg.sv
// Shared widths, the READY operand tag and the CDB tag-match helper for the reservation station.
package reservation_station_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned FU_INDEX  = 4;
  localparam int unsigned OCC_W     = 4;

  localparam logic [FU_INDEX-1:0] READY = FU_INDEX'(0);

  // A broadcast only wakes an operand that is still waiting on that producer.
  function automatic logic cdb_hit(input logic                cdb_valid,
                                   input logic [FU_INDEX-1:0] cdb_tag,
                                   input logic [FU_INDEX-1:0] tag);
    return cdb_valid && (tag != READY) && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder returning {found, index}.
module rs_prio_enc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: allocates entries on dispatch, snoops the CDB for pending
// operands and issues the lowest-index operand-complete entry to a single FU.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned OP_WIDTH    = 4,
  parameter int unsigned BASE_TAG    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [OP_WIDTH-1:0]  disp_op,
  input  logic [WORD_SIZE-1:0] disp_val1,
  input  logic [FU_INDEX-1:0]  disp_stat1,
  input  logic [WORD_SIZE-1:0] disp_val2,
  input  logic [FU_INDEX-1:0]  disp_stat2,
  output logic [FU_INDEX-1:0]  alloc_tag,
  input  logic                 cdb_valid,
  input  logic [FU_INDEX-1:0]  cdb_tag,
  input  logic [WORD_SIZE-1:0] cdb_data,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [OP_WIDTH-1:0]  iss_op,
  output logic [WORD_SIZE-1:0] iss_val1,
  output logic [WORD_SIZE-1:0] iss_val2,
  output logic [FU_INDEX-1:0]  iss_tag,
  output logic [OCC_W-1:0]     occupancy
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] busy;
  logic [OP_WIDTH-1:0]    op_q   [NUM_ENTRIES];
  logic [WORD_SIZE-1:0]   val1_q [NUM_ENTRIES];
  logic [WORD_SIZE-1:0]   val2_q [NUM_ENTRIES];
  logic [FU_INDEX-1:0]    tag1_q [NUM_ENTRIES];
  logic [FU_INDEX-1:0]    tag2_q [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] free_req;
  logic [NUM_ENTRIES-1:0] rdy_req;
  logic                   free_found;
  logic                   rdy_found;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       rdy_idx;
  logic                   disp_fire;
  logic                   iss_fire;
  logic                   bypass1;
  logic                   bypass2;
  logic [OCC_W-1:0]       occ;

  always_comb begin
    free_req = '0;
    rdy_req  = '0;
    occ      = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_req[i] = !busy[i];
      rdy_req[i]  = busy[i] && (tag1_q[i] == READY) && (tag2_q[i] == READY);
      occ         = occ + OCC_W'(busy[i]);
    end
  end

  rs_prio_enc #(.WIDTH(NUM_ENTRIES), .IDX_W(IDX_W)) u_free_sel (
    .req   (free_req),
    .found (free_found),
    .index (free_idx)
  );

  rs_prio_enc #(.WIDTH(NUM_ENTRIES), .IDX_W(IDX_W)) u_rdy_sel (
    .req   (rdy_req),
    .found (rdy_found),
    .index (rdy_idx)
  );

  assign disp_ready = free_found;
  assign alloc_tag  = FU_INDEX'(BASE_TAG) + FU_INDEX'(free_idx);
  assign occupancy  = occ;
  assign disp_fire  = disp_valid && free_found;
  assign iss_fire   = rdy_found && iss_ready;
  assign bypass1    = cdb_hit(cdb_valid, cdb_tag, disp_stat1);
  assign bypass2    = cdb_hit(cdb_valid, cdb_tag, disp_stat2);

  assign iss_valid = rdy_found;
  assign iss_op    = rdy_found ? op_q[rdy_idx]   : '0;
  assign iss_val1  = rdy_found ? val1_q[rdy_idx] : '0;
  assign iss_val2  = rdy_found ? val2_q[rdy_idx] : '0;
  assign iss_tag   = rdy_found ? (FU_INDEX'(BASE_TAG) + FU_INDEX'(rdy_idx)) : '0;

  // Dispatch targets a free entry and issue a busy one, so they never collide on an index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i]   <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        tag1_q[i] <= READY;
        tag2_q[i] <= READY;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (busy[i] && cdb_hit(cdb_valid, cdb_tag, tag1_q[i])) begin
          val1_q[i] <= cdb_data;
          tag1_q[i] <= READY;
        end
        if (busy[i] && cdb_hit(cdb_valid, cdb_tag, tag2_q[i])) begin
          val2_q[i] <= cdb_data;
          tag2_q[i] <= READY;
        end
        if (iss_fire && (rdy_idx == IDX_W'(i))) begin
          busy[i] <= 1'b0;
        end
        if (disp_fire && (free_idx == IDX_W'(i))) begin
          busy[i]   <= 1'b1;
          op_q[i]   <= disp_op;
          val1_q[i] <= bypass1 ? cdb_data : disp_val1;
          tag1_q[i] <= bypass1 ? READY : disp_stat1;
          val2_q[i] <= bypass2 ? cdb_data : disp_val2;
          tag2_q[i] <= bypass2 ? READY : disp_stat2;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, hand sequences, then random traffic
// against a slot-list reference model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int NE = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [3:0]           disp_op;
  logic [WORD_SIZE-1:0] disp_val1, disp_val2;
  logic [FU_INDEX-1:0]  disp_stat1, disp_stat2;
  logic [FU_INDEX-1:0]  alloc_tag;
  logic                 cdb_valid;
  logic [FU_INDEX-1:0]  cdb_tag;
  logic [WORD_SIZE-1:0] cdb_data;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [3:0]           iss_op;
  logic [WORD_SIZE-1:0] iss_val1, iss_val2;
  logic [FU_INDEX-1:0]  iss_tag;
  logic [OCC_W-1:0]     occupancy;

  int checks = 0;
  int errors = 0;

  reservation_station #(.NUM_ENTRIES(NE), .OP_WIDTH(4), .BASE_TAG(1)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_val1(disp_val1), .disp_stat1(disp_stat1),
    .disp_val2(disp_val2), .disp_stat2(disp_stat2),
    .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_val1(iss_val1), .iss_val2(iss_val2), .iss_tag(iss_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dv, op, v1, s1, v2, s2, cv, ct, cd, ir;
    int e_rdy, ca, e_alloc, e_occ, e_iv, e_op, e_v1, e_v2, e_tag;
  } vec_t;

  typedef struct {
    int                   slot;
    logic [3:0]           op;
    logic [WORD_SIZE-1:0] v1, v2;
    logic [FU_INDEX-1:0]  t1, t2;
  } ent_t;

  vec_t vt[$];
  ent_t q[$];

  function automatic vec_t mk(input int dv, op, v1, s1, v2, s2, cv, ct, cd, ir,
                              input int e_rdy, ca, e_alloc, e_occ, e_iv, e_op, e_v1, e_v2, e_tag);
    vec_t v;
    v.dv = dv; v.op = op; v.v1 = v1; v.s1 = s1; v.v2 = v2; v.s2 = s2;
    v.cv = cv; v.ct = ct; v.cd = cd; v.ir = ir;
    v.e_rdy = e_rdy; v.ca = ca; v.e_alloc = e_alloc; v.e_occ = e_occ; v.e_iv = e_iv;
    v.e_op = e_op; v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_tag = e_tag;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int dv, op, v1, s1, v2, s2, cv, ct, cd, ir);
    disp_valid = 1'(dv);  disp_op = 4'(op);
    disp_val1 = WORD_SIZE'(v1); disp_stat1 = FU_INDEX'(s1);
    disp_val2 = WORD_SIZE'(v2); disp_stat2 = FU_INDEX'(s2);
    cdb_valid = 1'(cv); cdb_tag = FU_INDEX'(ct); cdb_data = WORD_SIZE'(cd);
    iss_ready = 1'(ir);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
  endtask

  function automatic bit slot_used(input int s);
    foreach (q[k]) if (q[k].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lowest_free();
    for (int s = 0; s < NE; s++) if (!slot_used(s)) return s;
    return -1;
  endfunction

  // Position in q of the operand-complete entry with the smallest slot, or -1.
  function automatic int pick_issue();
    int best = -1;
    foreach (q[k])
      if (q[k].t1 == READY && q[k].t2 == READY && (best < 0 || q[k].slot < q[best].slot))
        best = k;
    return best;
  endfunction

  initial begin
    vt.push_back(mk(1,3,5,0,7,0,       0,0,0,     1, 1,1,1,0, 0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,       0,0,0,     1, 1,1,2,1, 1,3,5,7,1));
    vt.push_back(mk(1,2,'h11,2,9,0,    0,0,0,     1, 1,1,1,0, 0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,       1,2,'h55,  1, 1,1,2,1, 0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,       0,0,0,     1, 1,1,2,1, 1,2,'h55,9,1));
    vt.push_back(mk(1,6,'h22,3,4,0,    1,3,'hAA,  1, 1,1,1,0, 0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,       0,0,0,     1, 1,1,2,1, 1,6,'hAA,4,1));
    vt.push_back(mk(1,1,1,0,1,0,       0,0,0,     0, 1,1,1,0, 0,0,0,0,0));
    vt.push_back(mk(1,2,2,0,2,0,       0,0,0,     0, 1,1,2,1, 1,1,1,1,1));
    vt.push_back(mk(1,3,3,0,3,0,       0,0,0,     0, 1,1,3,2, 1,1,1,1,1));
    vt.push_back(mk(1,4,4,0,4,0,       0,0,0,     0, 1,1,4,3, 1,1,1,1,1));
    vt.push_back(mk(1,9,9,0,9,0,       0,0,0,     0, 0,0,0,4, 1,1,1,1,1));
    vt.push_back(mk(0,0,0,0,0,0,       0,0,0,     1, 0,0,0,4, 1,1,1,1,1));
    vt.push_back(mk(1,5,6,0,6,0,       0,0,0,     1, 1,1,1,3, 1,2,2,2,2));
    vt.push_back(mk(0,0,0,0,0,0,       0,0,0,     0, 1,1,2,3, 1,5,6,6,1));
    vt.push_back(mk(0,0,0,0,0,0,       0,0,0,     0, 1,1,2,3, 1,5,6,6,1));

    do_reset();
    chk("reset_iss_valid", 32'(iss_valid), 0);
    chk("reset_occupancy", 32'(occupancy), 0);
    chk("reset_disp_ready", 32'(disp_ready), 1);
    chk("reset_alloc_tag", 32'(alloc_tag), 1);

    foreach (vt[n]) begin
      chk($sformatf("v%0d_disp_ready", n), 32'(disp_ready), 32'(vt[n].e_rdy));
      if (vt[n].ca != 0) chk($sformatf("v%0d_alloc_tag", n), 32'(alloc_tag), 32'(vt[n].e_alloc));
      chk($sformatf("v%0d_occupancy", n), 32'(occupancy), 32'(vt[n].e_occ));
      chk($sformatf("v%0d_iss_valid", n), 32'(iss_valid), 32'(vt[n].e_iv));
      chk($sformatf("v%0d_iss_op", n), 32'(iss_op), 32'(vt[n].e_op));
      chk($sformatf("v%0d_iss_val1", n), 32'(iss_val1), 32'(vt[n].e_v1));
      chk($sformatf("v%0d_iss_val2", n), 32'(iss_val2), 32'(vt[n].e_v2));
      chk($sformatf("v%0d_iss_tag", n), 32'(iss_tag), 32'(vt[n].e_tag));
      drive(vt[n].dv, vt[n].op, vt[n].v1, vt[n].s1, vt[n].v2, vt[n].s2,
            vt[n].cv, vt[n].ct, vt[n].cd, vt[n].ir);
      tick();
    end

    // Reset with three busy entries and a pending issue.
    reset = 1'b1;
    #1;
    chk("midreset_iss_valid", 32'(iss_valid), 0);
    chk("midreset_occupancy", 32'(occupancy), 0);
    chk("midreset_disp_ready", 32'(disp_ready), 1);
    chk("midreset_alloc_tag", 32'(alloc_tag), 1);
    do_reset();

    // One broadcast wakes both operands; outputs hold while the FU stalls.
    drive(1, 7, 0, 2, 0, 2, 0, 0, 0, 0);
    tick();
    chk("both_wait_iss_valid", 32'(iss_valid), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2, 'h77, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      chk("both_iss_valid", 32'(iss_valid), 1);
      chk("both_iss_val1", 32'(iss_val1), 'h77);
      chk("both_iss_val2", 32'(iss_val2), 'h77);
      chk("both_iss_tag", 32'(iss_tag), 1);
      tick();
    end

    do_reset();
    for (int c = 0; c < 600; c++) begin
      int ef, ri;
      bit dv, ir, cv, fire_d, fire_i;
      logic [3:0] op;
      logic [WORD_SIZE-1:0] v1, v2, cd;
      logic [FU_INDEX-1:0] s1, s2, ct;
      ent_t ne;

      ef = lowest_free();
      ri = pick_issue();
      chk("rnd_disp_ready", 32'(disp_ready), 32'(q.size() < NE));
      if (ef >= 0) chk("rnd_alloc_tag", 32'(alloc_tag), 32'(ef + 1));
      chk("rnd_occupancy", 32'(occupancy), 32'(q.size()));
      chk("rnd_iss_valid", 32'(iss_valid), 32'(ri >= 0));
      if (ri >= 0) begin
        chk("rnd_iss_op", 32'(iss_op), 32'(q[ri].op));
        chk("rnd_iss_val1", 32'(iss_val1), 32'(q[ri].v1));
        chk("rnd_iss_val2", 32'(iss_val2), 32'(q[ri].v2));
        chk("rnd_iss_tag", 32'(iss_tag), 32'(q[ri].slot + 1));
      end

      dv = ($urandom_range(0, 9) < 6);
      ir = ($urandom_range(0, 1) == 1);
      cv = ($urandom_range(0, 1) == 1);
      op = 4'($urandom);
      v1 = WORD_SIZE'($urandom);
      v2 = WORD_SIZE'($urandom);
      cd = WORD_SIZE'($urandom);
      s1 = ($urandom_range(0, 1) == 1) ? READY : FU_INDEX'($urandom_range(1, 5));
      s2 = ($urandom_range(0, 1) == 1) ? READY : FU_INDEX'($urandom_range(1, 5));
      ct = FU_INDEX'($urandom_range(0, 5));
      drive(int'(dv), int'(op), int'(v1), int'(s1), int'(v2), int'(s2),
            int'(cv), int'(ct), int'(cd), int'(ir));

      fire_i = ir && (ri >= 0);
      fire_d = dv && (ef >= 0);
      foreach (q[k]) begin
        if (cv && q[k].t1 != READY && q[k].t1 == ct) begin q[k].v1 = cd; q[k].t1 = READY; end
        if (cv && q[k].t2 != READY && q[k].t2 == ct) begin q[k].v2 = cd; q[k].t2 = READY; end
      end
      if (fire_i) q.delete(ri);
      if (fire_d) begin
        ne.slot = ef; ne.op = op;
        ne.v1 = (cv && s1 != READY && s1 == ct) ? cd : v1;
        ne.t1 = (cv && s1 != READY && s1 == ct) ? READY : s1;
        ne.v2 = (cv && s2 != READY && s2 == ct) ? cd : v2;
        ne.t2 = (cv && s2 != READY && s2 == ct) ? READY : s2;
        q.push_back(ne);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
